// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register file write port; zero-sweeps r1..r31 after reset/ClearReq.
// Registered write 1 cycle after acceptance; one grant per cycle, none while sweeping or on ClearReq.
module regfile_write_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      ClearReq,
  input  logic [NUM_REQ-1:0]        ReqValid,
  input  logic [5*NUM_REQ-1:0]      ReqReg,
  input  logic [DATA_W*NUM_REQ-1:0] ReqData,
  output logic [NUM_REQ-1:0]        ReqReady,
  output logic                      RegWrite,
  output logic [4:0]                WriteRegister,
  output logic [DATA_W-1:0]         WriteData,
  output logic                      Busy
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } arbState_t;

  arbState_t         state;
  arbState_t         stateNext;
  logic [4:0]        clrIdx;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptrNext;

  logic              found;
  logic [PTR_W-1:0]  winner;
  logic [4:0]        selReg;
  logic [DATA_W-1:0] selData;
  logic              grantEn;
  int                scanIdx;

  // Rotating priority scan starting at ptr.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    selReg  = '0;
    selData = '0;
    scanIdx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scanIdx = int'(ptr) + k;
      if (scanIdx >= NUM_REQ) begin
        scanIdx = scanIdx - NUM_REQ;
      end
      if (!found && ReqValid[scanIdx]) begin
        found   = 1'b1;
        winner  = PTR_W'(scanIdx);
        selReg  = ReqReg[5*scanIdx +: 5];
        selData = ReqData[DATA_W*scanIdx +: DATA_W];
      end
    end
  end

  assign grantEn = (state == RUN) && !ClearReq && found;

  always_comb begin
    ReqReady = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ReqReady[i] = grantEn && (winner == PTR_W'(i));
    end
  end

  always_comb begin
    if (winner == PTR_W'(NUM_REQ - 1)) begin
      ptrNext = '0;
    end else begin
      ptrNext = winner + PTR_W'(1);
    end
  end

  assign Busy = (state == CLEAR);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= CLEAR;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      CLEAR:   if (clrIdx == 5'd31) stateNext = RUN;
      RUN:     if (ClearReq) stateNext = CLEAR;
      default: stateNext = CLEAR;
    endcase
  end

  // Write port datapath; address/data hold when no write is issued.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clrIdx        <= 5'd1;
      ptr           <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else if (state == CLEAR) begin
      RegWrite      <= 1'b1;
      WriteRegister <= clrIdx;
      WriteData     <= '0;
      if (clrIdx == 5'd31) begin
        clrIdx <= 5'd1;
      end else begin
        clrIdx <= clrIdx + 5'd1;
      end
    end else if (grantEn) begin
      ptr           <= ptrNext;
      RegWrite      <= (selReg != 5'd0);
      WriteRegister <= selReg;
      WriteData     <= selData;
    end else begin
      RegWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (NUM_REQ=2) with a shadow register file.
module tb_regfile_write_arbiter;

  logic        Clk;
  logic        Reset;
  logic        ClearReq;
  logic [1:0]  ReqValid;
  logic [9:0]  ReqReg;
  logic [63:0] ReqData;
  logic [1:0]  ReqReady;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        Busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] rf [32];

  regfile_write_arbiter #(.NUM_REQ(2), .DATA_W(32)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .ClearReq(ClearReq),
    .ReqValid(ReqValid),
    .ReqReg(ReqReg),
    .ReqData(ReqData),
    .ReqReady(ReqReady),
    .RegWrite(RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData(WriteData),
    .Busy(Busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Register file behaviour as seen by the arbiter outputs.
  always @(posedge Clk) begin
    if (RegWrite && WriteRegister != 5'd0) rf[WriteRegister] <= WriteData;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic setLane(input int lane, input logic [4:0] r, input logic [31:0] d);
    ReqReg[5*lane +: 5]   = r;
    ReqData[32*lane +: 32] = d;
  endtask

  task automatic sweepCheck(input string tag);
    for (int k = 1; k <= 31; k++) begin
      chk({tag, "_busy"}, 32'(Busy), 32'd1);
      chk({tag, "_rdy"}, 32'(ReqReady), 32'd0);
      @(negedge Clk);
      chk({tag, "_we"}, 32'(RegWrite), 32'd1);
      chk({tag, "_addr"}, 32'(WriteRegister), 32'(k));
      chk({tag, "_data"}, WriteData, 32'd0);
    end
    chk({tag, "_busy_end"}, 32'(Busy), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'hFFFF_FFFF;
    Reset    = 1'b1;
    ClearReq = 1'b0;
    ReqValid = 2'b00;
    ReqReg   = '0;
    ReqData  = '0;
    #1;
    chk("rst_we", 32'(RegWrite), 32'd0);
    chk("rst_addr", 32'(WriteRegister), 32'd0);
    chk("rst_data", WriteData, 32'd0);
    chk("rst_rdy", 32'(ReqReady), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd1);
    @(negedge Clk);
    Reset = 1'b0;

    // 1: power-on sweep
    sweepCheck("sweep1");
    @(negedge Clk);
    chk("idle_we", 32'(RegWrite), 32'd0);
    chk("idle_addr_hold", 32'(WriteRegister), 32'd31);
    chk("rf_r5_zero", rf[5], 32'd0);

    // 2: both lanes continuously valid
    setLane(0, 5'd5, 32'h11);
    setLane(1, 5'd6, 32'h22);
    ReqValid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("alt_rdy", 32'(ReqReady), (g % 2 == 0) ? 32'd1 : 32'd2);
      @(negedge Clk);
      chk("alt_we", 32'(RegWrite), 32'd1);
      chk("alt_addr", 32'(WriteRegister), (g % 2 == 0) ? 32'd5 : 32'd6);
      chk("alt_data", WriteData, (g % 2 == 0) ? 32'h11 : 32'h22);
    end
    ReqValid = 2'b00;
    #1;
    chk("none_rdy", 32'(ReqReady), 32'd0);

    // 3: write to x0 from lane1
    setLane(1, 5'd0, 32'hDEAD);
    ReqValid = 2'b10;
    #1;
    chk("x0_rdy", 32'(ReqReady), 32'd2);
    @(negedge Clk);
    chk("x0_we", 32'(RegWrite), 32'd0);

    // 4: same destination from both lanes
    setLane(0, 5'd7, 32'hAAAA);
    setLane(1, 5'd7, 32'hBBBB);
    ReqValid = 2'b11;
    #1;
    chk("x0_ptr_rdy", 32'(ReqReady), 32'd1);
    @(negedge Clk);
    chk("same_we0", 32'(RegWrite), 32'd1);
    chk("same_addr0", 32'(WriteRegister), 32'd7);
    chk("same_data0", WriteData, 32'hAAAA);
    ReqValid = 2'b10;
    #1;
    chk("same_rdy1", 32'(ReqReady), 32'd2);
    @(negedge Clk);
    chk("same_data1", WriteData, 32'hBBBB);
    ReqValid = 2'b00;
    @(negedge Clk);
    chk("same_we_off", 32'(RegWrite), 32'd0);
    chk("rf_r7", rf[7], 32'hBBBB);

    // 5: ClearReq in RUN with lane0 pending; a second ClearReq mid-sweep is ignored
    setLane(0, 5'd9, 32'h55);
    ReqValid = 2'b01;
    ClearReq = 1'b1;
    #1;
    chk("clr_rdy", 32'(ReqReady), 32'd0);
    @(negedge Clk);
    ClearReq = 1'b0;
    chk("clr_we", 32'(RegWrite), 32'd0);
    for (int k = 1; k <= 31; k++) begin
      ClearReq = (k == 10);
      chk("sweep2_busy", 32'(Busy), 32'd1);
      chk("sweep2_rdy", 32'(ReqReady), 32'd0);
      @(negedge Clk);
      chk("sweep2_addr", 32'(WriteRegister), 32'(k));
      chk("sweep2_we", 32'(RegWrite), 32'd1);
    end
    ClearReq = 1'b0;
    #1;
    chk("sweep2_busy_end", 32'(Busy), 32'd0);
    chk("post_clr_rdy", 32'(ReqReady), 32'd1);
    @(negedge Clk);
    chk("post_clr_addr", 32'(WriteRegister), 32'd9);
    chk("post_clr_data", WriteData, 32'h55);
    ReqValid = 2'b00;
    chk("rf_r7_cleared", rf[7], 32'd0);

    // 6: reset mid-sweep at index 12
    ClearReq = 1'b1;
    @(negedge Clk);
    ClearReq = 1'b0;
    for (int k = 1; k <= 12; k++) @(negedge Clk);
    chk("mid_addr12", 32'(WriteRegister), 32'd12);
    Reset = 1'b1;
    #1;
    chk("arst_we", 32'(RegWrite), 32'd0);
    chk("arst_addr", 32'(WriteRegister), 32'd0);
    chk("arst_busy", 32'(Busy), 32'd1);
    #1;
    Reset = 1'b0;
    sweepCheck("sweep3");
    setLane(0, 5'd3, 32'h1);
    setLane(1, 5'd4, 32'h2);
    ReqValid = 2'b11;
    #1;
    chk("ptr_after_rst", 32'(ReqReady), 32'd1);
    ReqValid = 2'b00;
    @(negedge Clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
